// File: rtl/and2_branch_gate.sv
// -----------------------------------------------------------------------------
// and2_branch_gate
//   Branch-qualify gate for the 16-bit single-cycle CPU. BNE_OUT is the
//   combinational AND of the decoder branch bit and the ALU zero flag. It
//   feeds PC-source selection. BNE_OUT_Q is a one-cycle-delayed copy of it.
//
//   Build option: define AND2_BRANCH_STATS_EN to build the saturating debug
//   counters eval_cnt (cycles with BNE=1) and taken_cnt (cycles with
//   BNE_OUT=1). Without the macro both counters read 0 and clr is ignored.
// -----------------------------------------------------------------------------
module and2_branch_gate #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             BNE,
    input  logic             Zero_I,
    input  logic             clr,
    output logic             BNE_OUT,
    output logic             BNE_OUT_Q,
    output logic [CNT_W-1:0] eval_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    logic decision_s;
    logic decision_q_r;

    // The branch decision is purely combinational and independent of clk,
    // rst_n and clr. This keeps it valid while reset is held.
    always_comb begin
        decision_s = BNE & Zero_I;
    end

    assign BNE_OUT = decision_s;

    // Delay the branch decision by one cycle for downstream debug and pipeline
    // use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decision_q_r <= 1'b0;
        end else begin
            decision_q_r <= decision_s;
        end
    end

    assign BNE_OUT_Q = decision_q_r;

`ifdef AND2_BRANCH_STATS_EN

    logic [CNT_W-1:0] eval_cnt_r;
    logic [CNT_W-1:0] taken_cnt_r;

    // Saturating increment: hold at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (val == {CNT_W{1'b1}}) begin
            res = val;
        end else begin
            res = val + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    // Statistics counters. clr wins over counting, so the sample taken in the
    // clearing cycle is dropped. Strict compares against 1'b1 make an X input
    // hold the count instead of incrementing it. Both counters saturate at the
    // same value, and taken_cnt only counts when eval_cnt also counts. As a
    // result taken_cnt never exceeds eval_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eval_cnt_r  <= {CNT_W{1'b0}};
            taken_cnt_r <= {CNT_W{1'b0}};
        end else if (clr == 1'b1) begin
            eval_cnt_r  <= {CNT_W{1'b0}};
            taken_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (BNE == 1'b1) begin
                eval_cnt_r <= sat_inc(eval_cnt_r);
            end else begin
                eval_cnt_r <= eval_cnt_r;
            end
            if (decision_s == 1'b1) begin
                taken_cnt_r <= sat_inc(taken_cnt_r);
            end else begin
                taken_cnt_r <= taken_cnt_r;
            end
        end
    end

    assign eval_cnt  = eval_cnt_r;
    assign taken_cnt = taken_cnt_r;

`else

    // Counters are not built. clr is deliberately left without a load.
    logic unused_clr_s;
    assign unused_clr_s = clr;

    assign eval_cnt  = {CNT_W{1'b0}};
    assign taken_cnt = {CNT_W{1'b0}};

`endif

endmodule

// File: tb/tb_and2_branch_gate.sv
// -----------------------------------------------------------------------------
// tb_and2_branch_gate
//   Directed bench for and2_branch_gate with CNT_W=4. The truth-table vectors
//   are driven from a table while reset is held. Hand-written sequences then
//   cover the one-cycle delay, counter saturation, the clr priority and an
//   asynchronous reset taken in the middle of a cycle. The expected counter
//   values follow the AND2_BRANCH_STATS_EN build option.
// -----------------------------------------------------------------------------
module tb_and2_branch_gate;

    localparam int CNT_W = 4;
    localparam int MAXV  = (1 << CNT_W) - 1;
`ifdef AND2_BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             BNE;
    logic             Zero_I;
    logic             clr;
    logic             BNE_OUT;
    logic             BNE_OUT_Q;
    logic [CNT_W-1:0] eval_cnt;
    logic [CNT_W-1:0] taken_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int m_eval  = 0;
    int m_taken = 0;
    int m_q     = 0;

    typedef struct {
        logic bne;
        logic zero;
        logic exp_out;
    } vec_t;

    vec_t vecs [8];

    and2_branch_gate #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .BNE       (BNE),
        .Zero_I    (Zero_I),
        .clr       (clr),
        .BNE_OUT   (BNE_OUT),
        .BNE_OUT_Q (BNE_OUT_Q),
        .eval_cnt  (eval_cnt),
        .taken_cnt (taken_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of stimulus. The inputs are driven on the falling edge
    // and checked 1 ns after the rising edge against the reference model.
    task automatic step(input logic b, input logic z, input logic c);
        @(negedge clk);
        BNE    = b;
        Zero_I = z;
        clr    = c;
        #1;
        check("bne_out_run", int'(BNE_OUT), int'(b & z));
        @(posedge clk);
        if (STATS) begin
            if (c) begin
                m_eval  = 0;
                m_taken = 0;
            end else begin
                if (b && m_eval < MAXV) m_eval++;
                if (b && z && m_taken < MAXV) m_taken++;
            end
        end
        m_q = int'(b & z);
        #1;
        check("bne_out_q", int'(BNE_OUT_Q), m_q);
        check("eval_cnt", int'(eval_cnt), m_eval);
        check("taken_cnt", int'(taken_cnt), m_taken);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0};

        rst_n  = 1'b0;
        BNE    = 1'b0;
        Zero_I = 1'b0;
        clr    = 1'b0;

        // Truth table while reset is held. The registered outputs must stay at 0.
        for (int i = 0; i < 8; i++) begin
            BNE    = vecs[i].bne;
            Zero_I = vecs[i].zero;
            #10;
            check("bne_out_tt", int'(BNE_OUT), int'(vecs[i].exp_out));
            check("q_in_reset", int'(BNE_OUT_Q), 0);
            check("eval_in_reset", int'(eval_cnt), 0);
            check("taken_in_reset", int'(taken_cnt), 0);
        end

        // Release reset away from a clock edge.
        @(negedge clk);
        rst_n = 1'b1;

        // One edge with BNE=1 and Zero_I=1 must give BNE_OUT_Q=1. Then 0 follows.
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);

        // Clear the counters, then run 20 edges with BNE=1 and Zero_I alternating.
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
        end
        check("eval_saturated", int'(eval_cnt), STATS ? 15 : 0);
        check("taken_after_20", int'(taken_cnt), STATS ? 10 : 0);

        // clr has priority over a counting sample in the same cycle.
        step(1'b1, 1'b1, 1'b1);
        check("eval_after_clr", int'(eval_cnt), 0);
        check("taken_after_clr", int'(taken_cnt), 0);

        // Count a few edges, then assert reset in the middle of a cycle.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("eval_before_rst", int'(eval_cnt), STATS ? 3 : 0);
        check("taken_before_rst", int'(taken_cnt), STATS ? 2 : 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("q_async_rst", int'(BNE_OUT_Q), 0);
        check("eval_async_rst", int'(eval_cnt), 0);
        check("taken_async_rst", int'(taken_cnt), 0);
        check("bne_out_async_rst", int'(BNE_OUT), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
